// File: rtl/rvc_asap_5pl_vga_fill_pkg.sv
// Shared types and constants for the VGA memory fill engine.
// Holds the FSM state encoding, memory geometry and cfg register offsets.
package rvc_asap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

  localparam int VGA_MEM_WORDS = 4096;
  localparam int WORD_W        = $clog2(VGA_MEM_WORDS);
  localparam int COUNT_W       = WORD_W + 1;

  localparam logic [1:0] CFG_BASE    = 2'd0;
  localparam logic [1:0] CFG_COUNT   = 2'd1;
  localparam logic [1:0] CFG_PATTERN = 2'd2;
  localparam logic [1:0] CFG_CMD     = 2'd3;

endpackage

// File: rtl/rvc_asap_5pl_vga_fill.sv
// Fills a word range of VGA memory port A with a pattern; the core always has priority.
// Latency: first write the cycle after start, done one cycle after the final write.
`ifndef RVC_MSFF
`define RVC_MSFF(q, d, rstval, clk, rst) \
  always_ff @(posedge clk) begin \
    if (rst) q <= rstval; \
    else     q <= d; \
  end
`endif

module rvc_asap_5pl_vga_fill
  import rvc_asap_pkg::*;
(
  input  logic        CLK_50,
  input  logic        Reset,
  input  logic [31:0] core_data,
  input  logic [31:0] core_address,
  input  logic [3:0]  core_byteena,
  input  logic        core_wren,
  input  logic        core_rden,
  output logic [31:0] core_q,
  input  logic        cfg_wren,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] mem_data,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_byteena,
  output logic        mem_wren,
  output logic        mem_rden,
  input  logic [31:0] mem_q
);

  fill_state_e        state_q, state_d;
  logic [WORD_W-1:0]  base_q, base_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [31:0]        pattern_q, pattern_d;
  logic [WORD_W-1:0]  cur_word_q, cur_word_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  logic [31:0]        fill_pat_q, fill_pat_d;

  logic core_req;
  logic cmd_wr;
  logic start_req;
  logic abort_req;
  logic grant;

  `RVC_MSFF(state_q,     state_d,     ST_IDLE,       CLK_50, Reset)
  `RVC_MSFF(base_q,      base_d,      '0,            CLK_50, Reset)
  `RVC_MSFF(count_q,     count_d,     '0,            CLK_50, Reset)
  `RVC_MSFF(pattern_q,   pattern_d,   '0,            CLK_50, Reset)
  `RVC_MSFF(cur_word_q,  cur_word_d,  '0,            CLK_50, Reset)
  `RVC_MSFF(remaining_q, remaining_d, '0,            CLK_50, Reset)
  `RVC_MSFF(fill_pat_q,  fill_pat_d,  '0,            CLK_50, Reset)

  always_comb begin
    core_req  = core_wren | core_rden;
    cmd_wr    = cfg_wren && (cfg_addr == CFG_CMD);
    abort_req = cmd_wr && cfg_data[1];
    start_req = cmd_wr && cfg_data[0] && !cfg_data[1];
    // Reset also gates the engine combinationally so a mid-fill reset writes nothing more.
    grant     = (state_q == ST_FILL) && !core_req && !Reset;
  end

  always_comb begin
    base_d      = base_q;
    count_d     = count_q;
    pattern_d   = pattern_q;
    cur_word_d  = cur_word_q;
    remaining_d = remaining_q;
    fill_pat_d  = fill_pat_q;
    state_d     = state_q;

    if (cfg_wren) begin
      case (cfg_addr)
        CFG_BASE:    base_d    = cfg_data[WORD_W-1:0];
        CFG_COUNT:   count_d   = cfg_data[COUNT_W-1:0];
        CFG_PATTERN: pattern_d = cfg_data;
        default:     ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          if (count_q != '0) begin
            state_d     = ST_FILL;
            cur_word_d  = base_q;
            remaining_d = count_q;
            fill_pat_d  = pattern_q;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_FILL: begin
        if (grant) begin
          cur_word_d  = cur_word_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
        end
        if (abort_req || (grant && remaining_q == COUNT_W'(1)))
          state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == ST_FILL);
    done        = (state_q == ST_DONE);
    core_q      = mem_q;
    mem_data    = '0;
    mem_address = '0;
    mem_byteena = '0;
    mem_wren    = 1'b0;
    mem_rden    = 1'b0;
    if (core_req) begin
      mem_data    = core_data;
      mem_address = core_address;
      mem_byteena = core_byteena;
      mem_wren    = core_wren;
      mem_rden    = core_rden;
    end else if (grant) begin
      mem_data    = fill_pat_q;
      mem_address = {{(30-WORD_W){1'b0}}, cur_word_q, 2'b00};
      mem_byteena = 4'hF;
      mem_wren    = 1'b1;
    end
  end

endmodule

// File: tb/tb_rvc_asap_5pl_vga_fill.sv
// Directed bench with a scoreboard: stimulus queues expected writes and done pulses,
// a negedge monitor pops and compares whenever the DUT writes or pulses done.
module tb_rvc_asap_5pl_vga_fill;

  logic        CLK_50 = 1'b0;
  logic        Reset;
  logic [31:0] core_data, core_address;
  logic [3:0]  core_byteena;
  logic        core_wren, core_rden;
  logic [31:0] core_q;
  logic        cfg_wren;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        busy, done;
  logic [31:0] mem_data, mem_address;
  logic [3:0]  mem_byteena;
  logic        mem_wren, mem_rden;
  logic [31:0] mem_q;

  rvc_asap_5pl_vga_fill dut (
    .CLK_50(CLK_50), .Reset(Reset),
    .core_data(core_data), .core_address(core_address), .core_byteena(core_byteena),
    .core_wren(core_wren), .core_rden(core_rden), .core_q(core_q),
    .cfg_wren(cfg_wren), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .busy(busy), .done(done),
    .mem_data(mem_data), .mem_address(mem_address), .mem_byteena(mem_byteena),
    .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_q(mem_q)
  );

  always #10 CLK_50 = ~CLK_50;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_done[$];
  wr_t mon_e;
  int  mon_c;
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  int  t;

  always @(posedge CLK_50) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge CLK_50) begin
    if (mem_wren === 1'b1) begin
      if (exp_wr.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write cyc=%0d addr=%h data=%h expected none", cyc, mem_address, mem_data);
      end else begin
        mon_e = exp_wr.pop_front();
        chk("wr_cycle", cyc, mon_e.cyc);
        chk("wr_addr", mem_address, mon_e.addr);
        chk("wr_data", mem_data, mon_e.data);
        chk("wr_be", {28'd0, mem_byteena}, {28'd0, mon_e.be});
      end
    end
    if (done === 1'b1) begin
      if (exp_done.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done cyc=%0d expected none", cyc);
      end else begin
        mon_c = exp_done.pop_front();
        chk("done_cycle", cyc, mon_c);
      end
    end
  end

  task automatic tick;
    @(posedge CLK_50);
    #1;
  endtask

  task automatic cfg(input logic [1:0] a, input logic [31:0] d);
    cfg_wren = 1'b1; cfg_addr = a; cfg_data = d;
  endtask

  task automatic cfg_idle;
    cfg_wren = 1'b0; cfg_addr = 2'd0; cfg_data = 32'd0;
  endtask

  task automatic push_wr(input int c, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_t e;
    e.cyc = c; e.addr = a; e.data = d; e.be = be;
    exp_wr.push_back(e);
  endtask

  task automatic setup(input logic [31:0] base, input logic [31:0] cnt, input logic [31:0] pat);
    tick; cfg(2'd0, base);
    tick; cfg(2'd1, cnt);
    tick; cfg(2'd2, pat);
  endtask

  task automatic drain_check(input string name);
    repeat (4) tick;
    chk({name, "_wr_left"}, exp_wr.size(), 0);
    chk({name, "_done_left"}, exp_done.size(), 0);
  endtask

  initial begin
    Reset = 1'b1;
    core_data = '0; core_address = '0; core_byteena = '0;
    core_wren = 1'b0; core_rden = 1'b0; mem_q = '0;
    cfg_idle();
    tick; tick;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wren", {31'd0, mem_wren}, 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    Reset = 1'b0;
    mem_q = 32'hCAFEF00D;
    tick;
    chk("core_q", core_q, 32'hCAFEF00D);
    mem_q = 32'd0;

    // Basic fill, with a base rewrite and a start while busy that must be ignored
    setup(32'd10, 32'd4, 32'hA5A5A5A5);
    tick; cfg(2'd3, 32'd1); t = cyc;
    for (int i = 0; i < 4; i++) push_wr(t + 1 + i, 32'((10 + i) * 4), 32'hA5A5A5A5, 4'hF);
    exp_done.push_back(t + 5);
    tick; cfg_idle();
    chk("busy_T1", {31'd0, busy}, 32'd1);
    tick; cfg(2'd0, 32'd500);
    tick; cfg(2'd3, 32'd1);
    tick; cfg_idle();
    chk("busy_T4", {31'd0, busy}, 32'd1);
    tick;
    chk("busy_T5", {31'd0, busy}, 32'd0);
    drain_check("basic");

    // Wrap from 4095 to 0
    setup(32'd4094, 32'd3, 32'h12345678);
    tick; cfg(2'd3, 32'd1); t = cyc;
    push_wr(t + 1, 32'd16376, 32'h12345678, 4'hF);
    push_wr(t + 2, 32'd16380, 32'h12345678, 4'hF);
    push_wr(t + 3, 32'd0,     32'h12345678, 4'hF);
    exp_done.push_back(t + 4);
    tick; cfg_idle();
    drain_check("wrap");

    // Core priority stalls the fill for two cycles
    setup(32'd100, 32'd5, 32'h0BADBEEF);
    tick; cfg(2'd3, 32'd1); t = cyc;
    push_wr(t + 1, 32'd400, 32'h0BADBEEF, 4'hF);
    tick; cfg_idle();
    tick;
    core_wren = 1'b1; core_address = 32'h0000_2000; core_data = 32'hDEAD0001; core_byteena = 4'h3;
    push_wr(t + 2, 32'h0000_2000, 32'hDEAD0001, 4'h3);
    tick;
    core_address = 32'h0000_2004; core_data = 32'hDEAD0002; core_byteena = 4'hC;
    push_wr(t + 3, 32'h0000_2004, 32'hDEAD0002, 4'hC);
    tick;
    core_wren = 1'b0; core_address = '0; core_data = '0; core_byteena = '0;
    for (int i = 0; i < 4; i++) push_wr(t + 4 + i, 32'((101 + i) * 4), 32'h0BADBEEF, 4'hF);
    exp_done.push_back(t + 8);
    repeat (3) tick;
    chk("busy_core_T7", {31'd0, busy}, 32'd1);
    drain_check("core");

    // Abort after three writes
    setup(32'd0, 32'd100, 32'h5A5A0000);
    tick; cfg(2'd3, 32'd1); t = cyc;
    for (int i = 0; i < 3; i++) push_wr(t + 1 + i, 32'(i * 4), 32'h5A5A0000, 4'hF);
    exp_done.push_back(t + 4);
    tick; cfg_idle();
    tick; tick; cfg(2'd3, 32'd2);
    tick; cfg_idle();
    chk("busy_abort_T4", {31'd0, busy}, 32'd0);
    drain_check("abort");

    // Start and abort together in IDLE: nothing happens
    tick; cfg(2'd3, 32'd3);
    tick; cfg_idle();
    chk("both_busy", {31'd0, busy}, 32'd0);
    drain_check("both");

    // Zero count goes straight to DONE
    setup(32'd7, 32'd0, 32'hFFFF0000);
    tick; cfg(2'd3, 32'd1); t = cyc;
    exp_done.push_back(t + 1);
    tick; cfg_idle();
    chk("zero_busy", {31'd0, busy}, 32'd0);
    drain_check("zero");

    // Reset mid-fill
    setup(32'd20, 32'd10, 32'h77777777);
    tick; cfg(2'd3, 32'd1); t = cyc;
    push_wr(t + 1, 32'd80, 32'h77777777, 4'hF);
    tick; cfg_idle();
    tick; Reset = 1'b1;
    tick; Reset = 1'b0;
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_done", {31'd0, done}, 32'd0);
    chk("rstmid_wren", {31'd0, mem_wren}, 32'd0);
    chk("rstmid_addr", mem_address, 32'd0);
    chk("rstmid_data", mem_data, 32'd0);
    chk("rstmid_be", {28'd0, mem_byteena}, 32'd0);
    drain_check("rstmid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
